// File: rtl/m65c02_int_sequencer.sv
// Interrupt/reset entry sequencer for the M65C02A core: drives the six-step
// push/vector/load-PC sequence and overrides the microcode NA_Op while Busy.
module m65c02_int_sequencer #(
    parameter logic [15:0] pNMI_Vec = 16'hFFFA,
    parameter logic [15:0] pRST_Vec = 16'hFFFC,
    parameter logic [15:0] pIRQ_Vec = 16'hFFFE
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rdy,
    input  logic        Done,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        BRK,
    input  logic        I,
    output logic        Busy,
    output logic        Int,
    output logic [10:0] NA_Op,
    output logic [15:0] VA,
    output logic        VA_Sel,
    output logic        WE,
    output logic [1:0]  DO_Sel,
    output logic        PSW_B,
    output logic        Ld_OP1,
    output logic        Ld_OP2,
    output logic        Set_I,
    output logic        Clr_D
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PSH_PCH = 3'd1,
        ST_PSH_PCL = 3'd2,
        ST_PSH_P   = 3'd3,
        ST_VEC_L   = 3'd4,
        ST_VEC_H   = 3'd5,
        ST_LD_PC   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_BRK = 2'd2,
        SRC_IRQ = 2'd3
    } src_t;

    localparam logic [10:0] NA_NONE = 11'b00_00000_000_0;
    localparam logic [10:0] NA_PUSH = 11'b00_01000_000_0;
    localparam logic [10:0] NA_LDPC = 11'b10_00010_000_0;

    // BRK shares the IRQ vector.
    function automatic logic [15:0] vec_base(input src_t src);
        logic [15:0] base;
        case (src)
            SRC_RST: base = pRST_Vec;
            SRC_NMI: base = pNMI_Vec;
            SRC_BRK: base = pIRQ_Vec;
            SRC_IRQ: base = pIRQ_Vec;
            default: base = pIRQ_Vec;
        endcase
        return base;
    endfunction

    state_t state_r;
    state_t state_s;
    src_t   src_r;
    src_t   src_s;
    logic   rst_pend_r;
    logic   rst_pend_s;
    logic   nmi_lat_r;
    logic   nmi_lat_s;
    logic   nmi_q_r;
    logic   nmi_rise_s;
    logic   irq_unmasked_s;
    logic   accept_nmi_s;

    // Request qualification: NMI rising edge and unmasked IRQ level.
    always_comb begin
        nmi_rise_s     = NMI & ~nmi_q_r;
        irq_unmasked_s = IRQ & ~I;
    end

    assign Int = nmi_lat_r | irq_unmasked_s;

    // Next-state, source selection and pending-request bookkeeping.
    always_comb begin
        state_s      = state_r;
        src_s        = src_r;
        rst_pend_s   = rst_pend_r;
        accept_nmi_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (Rdy & rst_pend_r) begin
                    state_s    = ST_PSH_PCH;
                    src_s      = SRC_RST;
                    rst_pend_s = 1'b0;
                end else if (Rdy & Done & (nmi_lat_r | nmi_rise_s)) begin
                    // A live edge counts so NMI beats a coincident BRK/IRQ.
                    state_s      = ST_PSH_PCH;
                    src_s        = SRC_NMI;
                    accept_nmi_s = 1'b1;
                end else if (Rdy & Done & BRK) begin
                    state_s = ST_PSH_PCH;
                    src_s   = SRC_BRK;
                end else if (Rdy & Done & irq_unmasked_s) begin
                    state_s = ST_PSH_PCH;
                    src_s   = SRC_IRQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PSH_PCH: begin
                if (Rdy) state_s = ST_PSH_PCL;
                else     state_s = ST_PSH_PCH;
            end
            ST_PSH_PCL: begin
                if (Rdy) state_s = ST_PSH_P;
                else     state_s = ST_PSH_PCL;
            end
            ST_PSH_P: begin
                if (Rdy) state_s = ST_VEC_L;
                else     state_s = ST_PSH_P;
            end
            ST_VEC_L: begin
                if (Rdy) state_s = ST_VEC_H;
                else     state_s = ST_VEC_L;
            end
            ST_VEC_H: begin
                if (Rdy) state_s = ST_LD_PC;
                else     state_s = ST_VEC_H;
            end
            ST_LD_PC: begin
                if (Rdy) state_s = ST_IDLE;
                else     state_s = ST_LD_PC;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // An edge survives an NMI acceptance only if the latch already held an
        // earlier edge, so one edge is never serviced twice.
        if (accept_nmi_s) begin
            nmi_lat_s = nmi_lat_r & nmi_rise_s;
        end else begin
            nmi_lat_s = nmi_lat_r | nmi_rise_s;
        end
    end

    // State, source and request registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= ST_IDLE;
            src_r      <= SRC_RST;
            rst_pend_r <= 1'b1;
            nmi_lat_r  <= 1'b0;
            nmi_q_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            src_r      <= src_s;
            rst_pend_r <= rst_pend_s;
            nmi_lat_r  <= nmi_lat_s;
            nmi_q_r    <= NMI;
        end
    end

    // Moore output decode plus Rdy-qualified load strobes.
    always_comb begin
        Busy   = 1'b0;
        NA_Op  = NA_NONE;
        VA     = vec_base(src_r);
        VA_Sel = 1'b0;
        WE     = 1'b0;
        DO_Sel = 2'd0;
        PSW_B  = 1'b0;
        Ld_OP1 = 1'b0;
        Ld_OP2 = 1'b0;
        Set_I  = 1'b0;
        Clr_D  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                Busy = 1'b0;
            end
            ST_PSH_PCH: begin
                Busy   = 1'b1;
                NA_Op  = NA_PUSH;
                WE     = 1'b1;
                DO_Sel = 2'd1;
            end
            ST_PSH_PCL: begin
                Busy   = 1'b1;
                NA_Op  = NA_PUSH;
                WE     = 1'b1;
                DO_Sel = 2'd2;
            end
            ST_PSH_P: begin
                Busy   = 1'b1;
                NA_Op  = NA_PUSH;
                WE     = 1'b1;
                DO_Sel = 2'd3;
                PSW_B  = (src_r == SRC_BRK);
            end
            ST_VEC_L: begin
                Busy   = 1'b1;
                VA_Sel = 1'b1;
                Ld_OP1 = Rdy;
            end
            ST_VEC_H: begin
                Busy   = 1'b1;
                VA_Sel = 1'b1;
                VA     = vec_base(src_r) + 16'd1;
                Ld_OP2 = Rdy;
            end
            ST_LD_PC: begin
                Busy  = 1'b1;
                NA_Op = NA_LDPC;
                Set_I = Rdy;
                Clr_D = Rdy;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_m65c02_int_sequencer.sv
// Self-checking bench for m65c02_int_sequencer: directed scenarios followed by
// random traffic, every cycle compared against a step-counting reference model.
module tb_m65c02_int_sequencer;

    logic        Clk = 1'b0;
    logic        Rst, Rdy, Done, NMI, IRQ, BRK, I;
    logic        Busy, Int, VA_Sel, WE, PSW_B, Ld_OP1, Ld_OP2, Set_I, Clr_D;
    logic [10:0] NA_Op;
    logic [15:0] VA;
    logic [1:0]  DO_Sel;

    always #5 Clk = ~Clk;

    m65c02_int_sequencer dut (
        .Clk(Clk), .Rst(Rst), .Rdy(Rdy), .Done(Done), .NMI(NMI), .IRQ(IRQ),
        .BRK(BRK), .I(I), .Busy(Busy), .Int(Int), .NA_Op(NA_Op), .VA(VA),
        .VA_Sel(VA_Sel), .WE(WE), .DO_Sel(DO_Sel), .PSW_B(PSW_B),
        .Ld_OP1(Ld_OP1), .Ld_OP2(Ld_OP2), .Set_I(Set_I), .Clr_D(Clr_D)
    );

    localparam int S_RST = 0;
    localparam int S_NMI = 1;
    localparam int S_BRK = 2;
    localparam int S_IRQ = 3;

    int n_total  = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int busy_cnt = 0;

    // Reference model: step 0 = idle, 1..6 = position in the entry sequence;
    // NMI edges are counted as outstanding service requests (at most one).
    int m_step;
    int m_src;
    int m_nmi_cnt;
    bit m_rst_pend;
    bit m_nmi_prev;

    function automatic logic [37:0] exp_out(input int step, input int src, input int nmi_cnt,
                                            input logic rdy, input logic irq, input logic i_f);
        logic [15:0] base;
        logic [10:0] na;
        logic [15:0] va;
        logic [1:0]  dsel;
        logic        busy, intr, vsel, we, pswb, l1, l2, si;
        base = (src == S_RST) ? 16'hFFFC : (src == S_NMI) ? 16'hFFFA : 16'hFFFE;
        busy = (step != 0);
        intr = (nmi_cnt != 0) || (irq && !i_f);
        na   = (step >= 1 && step <= 3) ? 11'b00_01000_000_0 :
               (step == 6) ? 11'b10_00010_000_0 : 11'd0;
        va   = (step == 5) ? base + 16'd1 : base;
        vsel = (step == 4) || (step == 5);
        we   = (step >= 1 && step <= 3);
        dsel = (step == 1) ? 2'd1 : (step == 2) ? 2'd2 : (step == 3) ? 2'd3 : 2'd0;
        pswb = (step == 3) && (src == S_BRK);
        l1   = (step == 4) && rdy;
        l2   = (step == 5) && rdy;
        si   = (step == 6) && rdy;
        return {busy, intr, na, va, vsel, we, dsel, pswb, l1, l2, si, si};
    endfunction

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs at negedge, compare outputs, then advance the model.
    task automatic cyc(input logic rst, input logic rdy, input logic done, input logic nmi,
                       input logic irq, input logic brk, input logic i_f, input string tag);
        logic [37:0] obs;
        int          avail;
        bit          rise;
        @(negedge Clk);
        Rst = rst; Rdy = rdy; Done = done; NMI = nmi; IRQ = irq; BRK = brk; I = i_f;
        #1;
        obs = {Busy, Int, NA_Op, VA, VA_Sel, WE, DO_Sel, PSW_B, Ld_OP1, Ld_OP2, Set_I, Clr_D};
        check(tag, obs, exp_out(m_step, m_src, m_nmi_cnt, rdy, irq, i_f));
        if (Busy === 1'b1) busy_cnt++;
        @(posedge Clk);
        if (rst) begin
            m_step = 0; m_src = S_RST; m_rst_pend = 1'b1; m_nmi_cnt = 0; m_nmi_prev = 1'b0;
        end else begin
            rise       = nmi && !m_nmi_prev;
            m_nmi_prev = nmi;
            avail      = m_nmi_cnt + (rise ? 1 : 0);
            if (m_step == 0 && rdy && m_rst_pend) begin
                m_step = 1; m_src = S_RST; m_rst_pend = 1'b0;
            end else if (m_step == 0 && rdy && done && (avail > 0 || brk || (irq && !i_f))) begin
                m_step = 1;
                if (avail > 0) begin
                    m_src = S_NMI;
                    avail = avail - 1;
                end else if (brk) begin
                    m_src = S_BRK;
                end else begin
                    m_src = S_IRQ;
                end
            end else if (m_step != 0 && rdy) begin
                m_step = (m_step == 6) ? 0 : m_step + 1;
            end
            m_nmi_cnt = (avail > 1) ? 1 : avail;
        end
    endtask

    initial begin
        logic r, rd, dn, nm, iq, bk, im;
        Rst = 1'b1; Rdy = 1'b0; Done = 1'b0; NMI = 1'b0; IRQ = 1'b0; BRK = 1'b0; I = 1'b0;
        @(posedge Clk);
        m_step = 0; m_src = S_RST; m_rst_pend = 1'b1; m_nmi_cnt = 0; m_nmi_prev = 1'b0;

        // Reset entry: two reset cycles, then six busy cycles to the reset vector.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
        busy_cnt = 0;
        for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_seq");
        check_int("rst_busy_len", busy_cnt, 6);

        // Unmasked IRQ at Done.
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "irq_accept");
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "irq_seq");
        check_int("irq_busy_len", busy_cnt, 6);

        // Masked IRQ: never accepted.
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "irq_masked");
        check_int("irq_masked_busy", busy_cnt, 0);

        // BRK beats IRQ; then NMI edge beats BRK in the same cycle.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "brk_accept");
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "brk_seq");
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "nmi_over_brk");
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nmi_seq");

        // NMI pulse during an IRQ sequence is held and serviced at the next Done.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "irq2_accept");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "irq2_pch");
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "irq2_pcl_nmi");
        for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "irq2_rest");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "nmi_late_accept");
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nmi_late_seq");

        // Rdy stall of three cycles in VEC_L stretches Busy to nine cycles.
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "stall_accept");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stall_push");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stall_vecl");
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stall_rest");
        check_int("stall_busy_len", busy_cnt, 9);

        // Rst during VEC_H of an NMI sequence, followed by the reset sequence.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "nmi3_accept");
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nmi3_seq");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "nmi3_rst_vech");
        busy_cnt = 0;
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst2_seq");
        check_int("rst2_busy_len", busy_cnt, 6);

        // Random traffic.
        nm = 1'b0;
        for (int k = 0; k < 500; k++) begin
            r  = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 3) != 0);
            dn = ($urandom_range(0, 2) == 0);
            bk = dn && ($urandom_range(0, 3) == 0);
            iq = ($urandom_range(0, 3) == 0);
            im = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 5) == 0) nm = ~nm;
            cyc(r, rd, dn, nm, iq, bk, im, "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
